// File: rtl/sram_word_ctrl_if.sv
// Request/response bundle between a word-access requester and sram_word_ctrl.
// The master issues 32-bit word requests; the slave returns read data as a single-cycle pulse.
interface sram_word_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [7:0]  req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_word_ctrl.sv
// Splits 32-bit word requests into four byte accesses on an 8-bit SRAM port.
// Read bytes are captured SRAM_LATENCY cycles after issue and reassembled into rsp_rdata.
module sram_word_ctrl #(
   parameter int SRAM_LATENCY = 1
) (
   input  logic               clk,
   input  logic               rst,
   sram_word_ctrl_if.slave    bus,
   output logic [9:0]         sram_addr,
   output logic [7:0]         sram_din,
   output logic               sram_wen,
   output logic               sram_sense_en,
   input  logic [7:0]         sram_dout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam logic [1:0] DRAIN_INIT = 2'(SRAM_LATENCY - 1);

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
      case (k)
         2'd0:    byte_sel = w[7:0];
         2'd1:    byte_sel = w[15:8];
         2'd2:    byte_sel = w[23:16];
         2'd3:    byte_sel = w[31:24];
         default: byte_sel = w[7:0];
      endcase
   endfunction

   state_t state_q, state_d;
   logic [1:0]  k_q, k_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [9:0]  sram_addr_q, sram_addr_d;
   logic [7:0]  sram_din_q, sram_din_d;
   logic        sram_wen_q, sram_wen_d;
   logic        sram_sense_en_q, sram_sense_en_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [SRAM_LATENCY-1:0]       pend_vld_q, pend_vld_d;
   logic [SRAM_LATENCY-1:0][1:0]  pend_idx_q, pend_idx_d;
   logic        req_ready_s;

   assign req_ready_s   = (state_q == ST_IDLE) && !rst;
   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign sram_addr     = sram_addr_q;
   assign sram_din      = sram_din_q;
   assign sram_wen      = sram_wen_q;
   assign sram_sense_en = sram_sense_en_q;

   // Next-state, next byte strobes (registered so they appear in the cycle they belong to) and read capture.
   always_comb begin
      state_d         = state_q;
      k_d             = k_q;
      cnt_d           = cnt_q;
      we_d            = we_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      be_d            = be_q;
      sram_addr_d     = sram_addr_q;
      sram_din_d      = sram_din_q;
      sram_wen_d      = 1'b0;
      sram_sense_en_d = 1'b0;
      rsp_valid_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_s) begin
               we_d        = bus.req_we;
               addr_d      = bus.req_addr;
               wdata_d     = bus.req_wdata;
               be_d        = bus.req_be;
               k_d         = 2'd0;
               state_d     = ST_ISSUE;
               sram_addr_d = {bus.req_addr, 2'd0};
               if (bus.req_we) begin
                  sram_wen_d = bus.req_be[0];
                  sram_din_d = bus.req_wdata[7:0];
               end else begin
                  sram_sense_en_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (k_q == 2'd3) begin
               if (we_q) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DRAIN;
                  cnt_d   = DRAIN_INIT;
               end
            end else begin
               k_d         = k_q + 2'd1;
               sram_addr_d = {addr_q, k_d};
               if (we_q) begin
                  sram_wen_d = be_q[k_d];
                  sram_din_d = byte_sel(wdata_q, k_d);
               end else begin
                  sram_sense_en_d = 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (cnt_q == 2'd0) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pending pipe: stage 0 records the byte on the SRAM port this cycle; the last stage names the byte on sram_dout.
      pend_vld_d[0] = sram_sense_en_q;
      pend_idx_d[0] = k_q;
      for (int i = 1; i < SRAM_LATENCY; i++) begin
         pend_vld_d[i] = pend_vld_q[i-1];
         pend_idx_d[i] = pend_idx_q[i-1];
      end

      rdata_d = rdata_q;
      if (pend_vld_q[SRAM_LATENCY-1]) begin
         rdata_d[{pend_idx_q[SRAM_LATENCY-1], 3'b000} +: 8] = sram_dout;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State, latched request, SRAM port and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         k_q             <= 2'd0;
         cnt_q           <= 2'd0;
         we_q            <= 1'b0;
         addr_q          <= 8'd0;
         wdata_q         <= 32'd0;
         be_q            <= 4'd0;
         sram_addr_q     <= 10'd0;
         sram_din_q      <= 8'd0;
         sram_wen_q      <= 1'b0;
         sram_sense_en_q <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rdata_q         <= 32'd0;
         pend_vld_q      <= '0;
         pend_idx_q      <= '0;
      end else begin
         state_q         <= state_d;
         k_q             <= k_d;
         cnt_q           <= cnt_d;
         we_q            <= we_d;
         addr_q          <= addr_d;
         wdata_q         <= wdata_d;
         be_q            <= be_d;
         sram_addr_q     <= sram_addr_d;
         sram_din_q      <= sram_din_d;
         sram_wen_q      <= sram_wen_d;
         sram_sense_en_q <= sram_sense_en_d;
         rsp_valid_q     <= rsp_valid_d;
         rdata_q         <= rdata_d;
         pend_vld_q      <= pend_vld_d;
         pend_idx_q      <= pend_idx_d;
      end
   end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Directed bench for sram_word_ctrl: one instance with a 1-cycle SRAM and one with a 3-cycle SRAM.
// Byte i of each SRAM model is preloaded with i[7:0] while rst is high.
module tb_sram_word_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   sram_word_ctrl_if bus1();
   sram_word_ctrl_if bus3();

   logic [9:0] addr1, addr3;
   logic [7:0] din1, din3, dout1, dout3;
   logic       wen1, wen3, sense1, sense3;
   logic [7:0] mem1 [1024];
   logic [7:0] mem3 [1024];
   logic [7:0] p3   [3];

   sram_word_ctrl #(.SRAM_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave),
      .sram_addr(addr1), .sram_din(din1), .sram_wen(wen1),
      .sram_sense_en(sense1), .sram_dout(dout1)
   );

   sram_word_ctrl #(.SRAM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3.slave),
      .sram_addr(addr3), .sram_din(din3), .sram_wen(wen3),
      .sram_sense_en(sense3), .sram_dout(dout3)
   );

   // 1-cycle SRAM model
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem1[i] <= 8'(i);
         dout1 <= 8'h00;
      end else begin
         if (wen1) mem1[addr1] <= din1;
         dout1 <= sense1 ? mem1[addr1] : 8'h00;
      end
   end

   // 3-cycle SRAM model
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem3[i] <= 8'(i);
         for (int j = 0; j < 3; j++) p3[j] <= 8'h00;
      end else begin
         if (wen3) mem3[addr3] <= din3;
         p3[0] <= sense3 ? mem3[addr3] : 8'h00;
         p3[1] <= p3[0];
         p3[2] <= p3[1];
      end
   end
   assign dout3 = p3[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic read1(input string tag, input logic [7:0] wa, input logic [31:0] exp);
      chk({tag, "_ready"}, 32'(bus1.req_ready), 32'd1);
      bus1.req_valid = 1'b1;
      bus1.req_we    = 1'b0;
      bus1.req_addr  = wa;
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk({tag, "_addr"},  32'(addr1), 32'({wa, 2'(k)}));
         chk({tag, "_sense"}, 32'(sense1), 32'd1);
         chk({tag, "_wen"},   32'(wen1), 32'd0);
         chk({tag, "_busy"},  32'(bus1.req_ready), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk({tag, "_drain_rv"}, 32'(bus1.rsp_valid), 32'd0);
      chk({tag, "_drain_se"}, 32'(sense1), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_rsp_valid"}, 32'(bus1.rsp_valid), 32'd1);
      chk({tag, "_rdata"}, bus1.rsp_rdata, exp);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_rv_off"}, 32'(bus1.rsp_valid), 32'd0);
      chk({tag, "_ready_again"}, 32'(bus1.req_ready), 32'd1);
   endtask

   task automatic write1(input string tag, input logic [7:0] wa, input logic [31:0] wd, input logic [3:0] be);
      chk({tag, "_ready"}, 32'(bus1.req_ready), 32'd1);
      bus1.req_valid = 1'b1;
      bus1.req_we    = 1'b1;
      bus1.req_addr  = wa;
      bus1.req_wdata = wd;
      bus1.req_be    = be;
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk({tag, "_addr"},  32'(addr1), 32'({wa, 2'(k)}));
         chk({tag, "_wen"},   32'(wen1), 32'(be[k]));
         chk({tag, "_din"},   32'(din1), 32'(wd[8*k +: 8]));
         chk({tag, "_sense"}, 32'(sense1), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk({tag, "_ready_again"}, 32'(bus1.req_ready), 32'd1);
      chk({tag, "_wen_off"}, 32'(wen1), 32'd0);
      chk({tag, "_rv"}, 32'(bus1.rsp_valid), 32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_rv;
      int n_se;
      bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 8'd0;
      bus1.req_wdata = 32'd0; bus1.req_be = 4'd0;
      bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = 8'd0;
      bus3.req_wdata = 32'd0; bus3.req_be = 4'd0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(bus1.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
      chk("rst_rdata", bus1.rsp_rdata, 32'd0);
      chk("rst_wen", 32'(wen1), 32'd0);
      chk("rst_sense", 32'(sense1), 32'd0);
      chk("rst_addr", 32'(addr1), 32'd0);
      chk("rst_din", 32'(din1), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      read1("rd_w3", 8'd3, 32'h0F0E0D0C);

      write1("wr_w5", 8'd5, 32'hAABBCCDD, 4'b0101);
      chk("mem20", 32'(mem1[20]), 32'h000000DD);
      chk("mem21", 32'(mem1[21]), 32'h00000015);
      chk("mem22", 32'(mem1[22]), 32'h000000BB);
      chk("mem23", 32'(mem1[23]), 32'h00000017);
      read1("rd_w5", 8'd5, 32'h17BB15DD);

      read1("rd_w255", 8'd255, 32'hFFFEFDFC);

      // Reset while a read is in flight: byte 0 in A+1, byte 1 in A+2, rst rises during A+3.
      bus1.req_valid = 1'b1;
      bus1.req_we    = 1'b0;
      bus1.req_addr  = 8'd7;
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_sense", 32'(sense1), 32'd0);
      chk("mid_rst_wen", 32'(wen1), 32'd0);
      chk("mid_rst_ready", 32'(bus1.req_ready), 32'd0);
      chk("mid_rst_rdata", bus1.rsp_rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(bus1.req_ready), 32'd1);
      n_rv = 0;
      n_se = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus1.rsp_valid) n_rv++;
         if (sense1 || wen1) n_se++;
      end
      chk("post_rst_no_rsp", 32'(n_rv), 32'd0);
      chk("post_rst_no_strobe", 32'(n_se), 32'd0);
      read1("rd_w0", 8'd0, 32'h03020100);

      // Latency-3 instance: rsp_valid exactly 8 cycles after accept.
      bus3.req_valid = 1'b1;
      bus3.req_we    = 1'b0;
      bus3.req_addr  = 8'd1;
      @(posedge clk); #1;
      bus3.req_valid = 1'b0;
      n_rv = 0;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         if (bus3.rsp_valid) n_rv++;
         @(posedge clk); #1;
      end
      chk("l3_early_rsp", 32'(n_rv), 32'd0);
      @(negedge clk);
      chk("l3_rsp_valid", 32'(bus3.rsp_valid), 32'd1);
      chk("l3_rdata", bus3.rsp_rdata, 32'h07060504);
      @(posedge clk); #1;
      @(negedge clk);
      chk("l3_ready_again", 32'(bus3.req_ready), 32'd1);
      chk("l3_rv_off", 32'(bus3.rsp_valid), 32'd0);

      // req_valid held across a write then a read of the same word.
      bus1.req_valid = 1'b1;
      bus1.req_we    = 1'b1;
      bus1.req_addr  = 8'd2;
      bus1.req_wdata = 32'h11223344;
      bus1.req_be    = 4'hF;
      @(posedge clk); #1;
      bus1.req_we    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b2b_wr_busy", 32'(bus1.req_ready), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("b2b_ready_a5", 32'(bus1.req_ready), 32'd1);
      @(posedge clk); #1;
      bus1.req_valid = 1'b0;
      n_rv = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("b2b_rd_busy", 32'(bus1.req_ready), 32'd0);
         if (bus1.rsp_valid) n_rv++;
         @(posedge clk); #1;
      end
      chk("b2b_early_rsp", 32'(n_rv), 32'd0);
      @(negedge clk);
      chk("b2b_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
      chk("b2b_rdata", bus1.rsp_rdata, 32'h11223344);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_ready_again", 32'(bus1.req_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sram_word_ctrl.md
# sram_word_ctrl

Word-access controller that sits directly upstream of the 8-bit, 1024-entry behavioural SRAM (`sram_behav`). It accepts 32-bit read/write requests on a valid/ready handshake, splits each into four byte accesses on the SRAM's `addr/din/wen/sense_en` port, and reassembles read bytes into a 32-bit response. Reads are pipelined: one byte is issued per cycle, and each byte is captured `SRAM_LATENCY` cycles after it is issued.

## Interface
Parameters:
- `SRAM_LATENCY`, 1: cycles from the `sense_en` issue edge to the capture edge of `sram_dout`. Legal range is 1..4; it must match the attached SRAM.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  word address (256 words).
- `req_wdata`  in  32  write data, little-endian bytes.
- `req_be`  in  4  write byte enables; ignored for reads.
- `rsp_valid`  out  1  one-cycle pulse, read data valid; no backpressure.
- `rsp_rdata`  out  32  read data.
- `sram_addr`  out  10  SRAM byte address.
- `sram_din`  out  8  SRAM write byte.
- `sram_wen`  out  1  SRAM write enable.
- `sram_sense_en`  out  1  SRAM read enable.
- `sram_dout`  in  8  SRAM read byte.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - ISSUE: 4 cycles, byte counter k=0..3.
  - DRAIN: waits for the last read capture.
  - RESP: 1 cycle, `rsp_valid`=1.
- Accept condition: `req_valid && req_ready` at a rising edge. On accept, latch `req_we`, `req_addr`, `req_wdata` and `req_be`, then go to ISSUE with k=0.
- ISSUE, byte k:
  - `sram_addr` = {latched addr, k[1:0]}.
  - Write: `sram_wen` = be[k], `sram_din` = wdata[8k+7:8k], `sram_sense_en` = 0. A disabled byte still consumes its cycle, with `sram_wen` = 0.
  - Read: `sram_sense_en` = 1, `sram_wen` = 0.
- After k=3:
  - Write: go to IDLE. Writes produce no response.
  - Read: go to DRAIN for `SRAM_LATENCY` cycles, then RESP.
- Read capture:
  - Use a `SRAM_LATENCY`-deep pending pipe carrying the byte index.
  - The byte issued in cycle c is captured from `sram_dout` at the end of cycle c+`SRAM_LATENCY` into `rsp_rdata[8k+7:8k]`.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. `rsp_rdata` holds its value until the next read's first capture.
- `sram_wen` and `sram_sense_en` are never both 1. Outside ISSUE, both are 0 and `sram_addr`/`sram_din` hold their last values.
- `req_ready` = (state==IDLE) && !rst. Requests presented while busy are not accepted and must be held by the requester.

## Timing
- Reset, asserted asynchronously:
  - state = IDLE.
  - `req_ready`=0 while `rst`=1.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - `sram_wen`=0, `sram_sense_en`=0, `sram_addr`=0, `sram_din`=0.
  - Pending pipe cleared.
  - First acceptable edge is the first rising edge after deassertion.
- Reset mid-operation drops the in-flight request. No further SRAM strobes and no `rsp_valid` for that request.
- Write, accepted at edge A: strobes in cycles A+1..A+4; `req_ready`=1 in cycle A+5. Occupancy is 4 cycles.
- Read, accepted at edge A: `sense_en` in cycles A+1..A+4; DRAIN in A+5..A+4+L; `rsp_valid` in cycle A+5+L; `req_ready`=1 in cycle A+6+L. With L=1, `rsp_valid` is in cycle A+6.
- Back-to-back: a request held valid is accepted on the first edge in which the controller is in IDLE. There is no overlap between requests.
- Address wrap: word 255, byte 3 maps to `sram_addr` 1023. There is no carry beyond that.

## Test plan
- Reset release, SRAM preloaded with data[i]=i, read word 3 -> `sram_addr` steps 12,13,14,15 with `sense_en`=1; `rsp_valid` 6 cycles after accept; `rsp_rdata`=0x0F0E0D0C.
- Write word 5, wdata=0xAABBCCDD, be=4'b0101, then read word 5 -> SRAM bytes 20=0xDD and 22=0xBB written; `wen`=0 on addrs 21 and 23; read returns 0x17BB15DD.
- Read word 255 -> addrs 1020..1023; `rsp_rdata`=0xFFFEFDFC (8-bit truncated init).
- Assert `rst` in the cycle after issuing byte 1 of a read -> strobes drop to 0 immediately, `rsp_valid` never asserts, `req_ready`=1 on the first cycle after `rst` deasserts, and a following read of word 0 returns 0x03020100.
- `SRAM_LATENCY`=3 with matching SRAM model, read word 1 -> `rsp_valid` 8 cycles after accept, data 0x07060504.
- `req_valid` held high over write(word 2, 0x11223344, be=4'hF) then read(word 2) -> second request accepted in cycle A+5 of the first; read returns 0x11223344; `req_ready` low throughout both transactions.
